pipe_ctrl: RTL and testbench

//   Central pipeline hazard/flush controller for the MIPS core; successor to the fixed 6-bit stall decoder.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/stall_prio_mask.sv | 23 ++
 rtl/pipe_ctrl.sv | 84 ++++++++
 tb/tb_pipe_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage indices, controller state type and width helper for pipe_ctrl
package pipe_pkg;
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;
  typedef enum logic {IDLE, FLUSH} ctrl_state_e;
  function automatic int clog2s(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stall_prio_mask.sv
// stall_prio_mask: highest-set-bit encoder over req_i[N-1:1] giving thermometer mask_o[i:0] and index idx_o
module stall_prio_mask
  import pipe_pkg::*;
#(
  parameter int N = 6,
  localparam int W = clog2s(N)
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] mask_o,
  output logic [W-1:0] idx_o
);
  logic unused_req0;
  assign unused_req0 = req_i[STG_PC];
  always_comb begin
    mask_o = '0;
    idx_o  = '0;
    for (int i = STG_IF; i < N; i++)
      if (req_i[i]) begin
        mask_o = {N{1'b1}} >> (N - 1 - i);
        idx_o  = W'(i);
      end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller; ports clk, rst, stallreq, excp_req, excp_target -> stall, stall_src, flush, new_pc, wdt_err; optional watchdog under PIPE_STALL_WDT_EN
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int NSTAGE    = 6,
  parameter int ADDR_W    = 32,
  parameter int FLUSH_CYC = 1,
  parameter int WDT_LIMIT = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NSTAGE-1:0]           stallreq,
  input  logic                        excp_req,
  input  logic [ADDR_W-1:0]           excp_target,
  output logic [NSTAGE-1:0]           stall,
  output logic [clog2s(NSTAGE)-1:0]   stall_src,
  output logic                        flush,
  output logic [ADDR_W-1:0]           new_pc,
  output logic                        wdt_err
);
  localparam int SW = clog2s(NSTAGE);
  localparam int CW = clog2s(FLUSH_CYC + 1);
  localparam logic [CW-1:0] CNT_START = CW'(FLUSH_CYC - 1);
  ctrl_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [NSTAGE-1:0] mask;
  logic [SW-1:0]     idx;
  stall_prio_mask #(.N(NSTAGE)) u_prio (
    .req_i  (stallreq),
    .mask_o (mask),
    .idx_o  (idx)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  // a fresh request always restarts the window, so the latest target wins
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    if (excp_req) begin
      state_d = FLUSH;
      cnt_d   = CNT_START;
      tgt_d   = excp_target;
    end else if (state_q == FLUSH) begin
      state_d = (cnt_q == '0) ? IDLE : FLUSH;
      cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
    end
  end
  assign flush     = (state_q == FLUSH);
  assign new_pc    = tgt_q;
  assign stall     = (rst || flush) ? '0 : mask;
  assign stall_src = (rst || flush) ? '0 : idx;
`ifdef PIPE_STALL_WDT_EN
  localparam int WW = clog2s(WDT_LIMIT + 1);
  localparam logic [WW-1:0] WLIM = WW'(WDT_LIMIT);
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          werr_q, werr_d;
  always_comb begin
    wcnt_d = (stall == '0) ? '0 : ((wcnt_q == WLIM) ? wcnt_q : wcnt_q + WW'(1));
    werr_d = werr_q | (wcnt_d == WLIM);
  end
  always_ff @(posedge clk)
    if (rst) begin
      wcnt_q <= '0;
      werr_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      werr_q <= werr_d;
    end
  assign wdt_err = werr_q;
`else
  localparam int unused_wdt_limit = WDT_LIMIT;
  assign wdt_err = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl (table vectors, corner sequences, randomized model compare)
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [5:0]  stallreq = '0;
  logic        excp_req = 1'b0;
  logic [31:0] excp_target = '0;
  logic [5:0]  stall;
  logic [2:0]  stall_src;
  logic        flush;
  logic [31:0] new_pc;
  logic        wdt_err;
  logic [7:0]  stallreq8 = '0;
  logic        excp8 = 1'b0;
  logic [31:0] tgt8 = '0;
  logic [7:0]  stall8;
  logic [2:0]  src8;
  logic        flush8;
  logic [31:0] npc8;
  logic        wdt8;
  pipe_ctrl #(.NSTAGE(6), .ADDR_W(32), .FLUSH_CYC(3), .WDT_LIMIT(16)) u0 (
    .clk(clk), .rst(rst), .stallreq(stallreq), .excp_req(excp_req), .excp_target(excp_target),
    .stall(stall), .stall_src(stall_src), .flush(flush), .new_pc(new_pc), .wdt_err(wdt_err)
  );
  pipe_ctrl #(.NSTAGE(8), .ADDR_W(32), .FLUSH_CYC(1), .WDT_LIMIT(16)) u1 (
    .clk(clk), .rst(rst), .stallreq(stallreq8), .excp_req(excp8), .excp_target(tgt8),
    .stall(stall8), .stall_src(src8), .flush(flush8), .new_pc(npc8), .wdt_err(wdt8)
  );
  int checks = 0;
  int errors = 0;
  int rem = 0;
  logic [31:0] mtgt = '0;
  always @(posedge clk)
    if (rst) begin
      rem  <= 0;
      mtgt <= '0;
    end else if (excp_req) begin
      rem  <= 3;
      mtgt <= excp_target;
    end else if (rem > 0) rem <= rem - 1;
  function automatic int hi_req(input logic [7:0] r, input int n);
    int h = 0;
    for (int i = 1; i < n; i++) if (r[i]) h = i;
    return h;
  endfunction
  function automatic logic [7:0] therm(input int h);
    return (h == 0) ? 8'h00 : 8'((1 << (h + 1)) - 1);
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  typedef struct {logic [5:0] req; logic [5:0] st; logic [2:0] src;} vec_t;
  vec_t tbl[8];
  initial begin
    logic [7:0] e;
    int h;
    tbl[0] = '{6'b001000, 6'b001111, 3'd3};
    tbl[1] = '{6'b000100, 6'b000111, 3'd2};
    tbl[2] = '{6'b011100, 6'b011111, 3'd4};
    tbl[3] = '{6'b000000, 6'b000000, 3'd0};
    tbl[4] = '{6'b000001, 6'b000000, 3'd0};
    tbl[5] = '{6'b100000, 6'b111111, 3'd5};
    tbl[6] = '{6'b000010, 6'b000011, 3'd1};
    tbl[7] = '{6'b100011, 6'b111111, 3'd5};
    repeat (2) step();
    stallreq = 6'b001000;
    stallreq8 = 8'h80;
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_src", stall_src, 0);
    chk("rst_flush", flush, 0);
    chk("rst_new_pc", new_pc, 0);
    chk("rst_wdt", wdt_err, 0);
    chk("rst_stall8", stall8, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      stallreq = tbl[i].req;
      #1;
      chk("tbl_stall", stall, tbl[i].st);
      chk("tbl_src", stall_src, tbl[i].src);
    end
    stallreq = '0;
    #1;
    chk("n8_stall", stall8, 8'hFF);
    chk("n8_src", src8, 7);
    stallreq8 = '0;
    step();
    stallreq = 6'b001000;
    excp_req = 1'b1;
    excp_target = 32'hBFC00380;
    @(negedge clk);
    chk("t3_same_cycle_stall", stall, 6'b001111);
    chk("t3_no_flush_yet", flush, 0);
    step();
    excp_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_flush", flush, 1);
      chk("t3_new_pc", new_pc, 32'hBFC00380);
      chk("t3_stall_during_flush", stall, 0);
      step();
    end
    @(negedge clk);
    chk("t3_flush_end", flush, 0);
    chk("t3_stall_back", stall, 6'b001111);
    chk("t3_new_pc_hold", new_pc, 32'hBFC00380);
    step();
    stallreq = '0;
    excp_req = 1'b1;
    excp_target = 32'h12345678;
    step();
    excp_req = 1'b0;
    @(negedge clk);
    chk("t4_c1_flush", flush, 1);
    step();
    excp_req = 1'b1;
    excp_target = 32'h80000180;
    @(negedge clk);
    chk("t4_c2_flush", flush, 1);
    chk("t4_c2_pc", new_pc, 32'h12345678);
    step();
    excp_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_reflush", flush, 1);
      chk("t4_new_pc", new_pc, 32'h80000180);
      step();
    end
    @(negedge clk);
    chk("t4_flush_end", flush, 0);
    excp_req = 1'b1;
    excp_target = 32'hBFC00380;
    step();
    excp_req = 1'b0;
    stallreq = 6'b001000;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_cycle_stall", stall, 0);
    step();
    rst = 1'b0;
    stallreq = '0;
    @(negedge clk);
    chk("t5_flush_aborted", flush, 0);
    chk("t5_new_pc", new_pc, 0);
    chk("t5_stall", stall, 0);
    step();
    @(negedge clk);
    chk("t5_still_idle", flush, 0);
    excp8 = 1'b1;
    tgt8 = 32'h00001234;
    stallreq8 = 8'h80;
    step();
    excp8 = 1'b0;
    @(negedge clk);
    chk("n8_flush", flush8, 1);
    chk("n8_new_pc", npc8, 32'h00001234);
    chk("n8_flush_stall", stall8, 0);
    step();
    @(negedge clk);
    chk("n8_flush_one_cycle", flush8, 0);
    chk("n8_stall_back", stall8, 8'hFF);
    stallreq8 = '0;
`ifdef PIPE_STALL_WDT_EN
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    stallreq = 6'b001000;
    repeat (15) step();
    @(negedge clk);
    chk("wdt_15", wdt_err, 0);
    step();
    stallreq = '0;
    @(negedge clk);
    chk("wdt_16", wdt_err, 1);
    repeat (3) step();
    @(negedge clk);
    chk("wdt_sticky", wdt_err, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("wdt_rst_clear", wdt_err, 0);
    stallreq = 6'b001000;
    repeat (15) step();
    stallreq = '0;
    step();
    stallreq = 6'b001000;
    repeat (5) step();
    @(negedge clk);
    chk("wdt_gap_clears", wdt_err, 0);
    stallreq = '0;
`else
    stallreq = 6'b001000;
    repeat (20) step();
    @(negedge clk);
    chk("wdt_tied0", wdt_err, 0);
    stallreq = '0;
`endif
    for (int n = 0; n < 300; n++) begin
      step();
      stallreq = 6'($urandom);
      excp_req = ($urandom_range(0, 7) == 0);
      excp_target = $urandom;
      stallreq8 = 8'($urandom);
      @(negedge clk);
      h = hi_req({2'b00, stallreq}, 6);
      e = (rem > 0) ? 8'h00 : therm(h);
      chk("rnd_flush", flush, (rem > 0));
      chk("rnd_new_pc", new_pc, mtgt);
      chk("rnd_stall", stall, e[5:0]);
      chk("rnd_src", stall_src, (rem > 0) ? 0 : h);
      h = hi_req(stallreq8, 8);
      chk("rnd_stall8", stall8, therm(h));
      chk("rnd_src8", src8, h);
    end
    excp_req = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
